// File: rtl/hilo_mdu_pkg.sv
// Shared constants and types for the EX-stage HI/LO multiply/divide unit.
// Holds the ex_hilo bus layout, the FSM encoding and the divide-by-zero LO value.
package hilo_mdu_pkg;

    localparam int          EX_HILO_WD     = 66;
    localparam int          MDU_DIV_CYCLES = 32;
    localparam logic [31:0] DIV_ZERO_LO    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MDU_IDLE   = 2'd0,
        MDU_DIV_ON = 2'd1,
        MDU_MUL_ON = 2'd2,
        MDU_DONE   = 2'd3
    } mdu_state_e;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_wdata;
        logic [31:0] lo_wdata;
    } ex_hilo_t;

    // Magnitude of a signed operand; unsigned operands pass through untouched.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring divider: one quotient bit per cycle over a 64-bit {rem, quo} register.
// In mul_mode the same register and counter run an unsigned shift-add multiply; product = {remainder, quotient}.
module mdu_div_core
    import hilo_mdu_pkg::*;
#(
    parameter int ITERS = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mul_mode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_W = $clog2(ITERS);

    logic [63:0]      acc;
    logic [63:0]      acc_nxt;
    logic [31:0]      divisor;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             mul_q;
    logic [32:0]      trial;
    logic [32:0]      sum;

    // Top 33 bits are the shifted partial remainder with the next dividend bit brought in.
    assign trial = acc[63:31] - {1'b0, divisor};
    assign sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor} : 33'd0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        acc_nxt = {acc[62:0], 1'b0};
        if (mul_q) begin
            acc_nxt = {sum, acc[31:1]};
        end else if (!trial[32]) begin
            acc_nxt = {trial[31:0], acc[30:0], 1'b1};
        end
    end

    assign done      = running && (cnt == CNT_W'(ITERS - 1));
    assign quotient  = acc_nxt[31:0];
    assign remainder = acc_nxt[63:32];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            divisor <= '0;
            cnt     <= '0;
            running <= 1'b0;
            mul_q   <= 1'b0;
        end else if (start) begin
            acc     <= {32'd0, op_a};
            divisor <= op_b;
            cnt     <= '0;
            running <= 1'b1;
            mul_q   <= mul_mode;
        end else if (running) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit driving the ex_hilo write bus into ID's HI/LO registers.
// Define MDU_MULT_ITER_EN to run mult/multu on the shared 32-cycle iterative core.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_mult,
    input  logic                  inst_multu,
    input  logic                  inst_div,
    input  logic                  inst_divu,
    input  logic                  inst_mthi,
    input  logic                  inst_mtlo,
    input  logic [31:0]           src_a,
    input  logic [31:0]           src_b,
    input  logic                  ex_stall,
    output logic [EX_HILO_WD-1:0] ex_hilo,
    output logic                  stallreq,
    output logic                  busy
);

    mdu_state_e  state;
    mdu_state_e  state_nxt;
    logic        is_div;
    logic        is_mul;
    logic        op_signed;
    logic        div_by_zero;
    logic        core_start;
    logic        core_done;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] core_quo;
    logic [31:0] core_rem;
    logic [63:0] core_res;
    logic [63:0] prod_fix;
    logic [31:0] hi_res;
    logic [31:0] lo_res;
    logic        neg_hi;
    logic        neg_lo;
    logic        mul_op;
    ex_hilo_t    hilo_bus;

`ifdef MDU_MULT_ITER_EN
    localparam logic ITER_MUL = 1'b1;
`else
    localparam logic ITER_MUL = 1'b0;
    logic [63:0] s_prod;
    logic [63:0] u_prod;

    assign s_prod = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign u_prod = {32'd0, src_a} * {32'd0, src_b};
`endif

    assign is_div      = inst_div | inst_divu;
    assign is_mul      = inst_mult | inst_multu;
    assign op_signed   = inst_div | inst_mult;
    assign div_by_zero = (src_b == 32'd0);
    assign a_mag       = mag32(src_a, op_signed);
    assign b_mag       = mag32(src_b, op_signed);
    assign core_start  = (state == MDU_IDLE) && ((is_div && !div_by_zero) || (is_mul && ITER_MUL));
    assign core_res    = {core_rem, core_quo};
    assign prod_fix    = neg_lo ? (~core_res + 64'd1) : core_res;

    mdu_div_core #(
        .ITERS     (DIV_CYCLES)
    ) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (core_start),
        .mul_mode  (is_mul),
        .op_a      (a_mag),
        .op_b      (b_mag),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MDU_IDLE: begin
                if (is_div) begin
                    state_nxt = div_by_zero ? MDU_DONE : MDU_DIV_ON;
                end else if (is_mul) begin
                    state_nxt = MDU_MUL_ON;
                end
            end
            MDU_DIV_ON: if (core_done) state_nxt = MDU_DONE;
            MDU_MUL_ON: if (!ITER_MUL || core_done) state_nxt = MDU_DONE;
            // The instruction leaves EX on the same edge we return to IDLE, so it cannot re-issue.
            MDU_DONE:   if (!ex_stall) state_nxt = MDU_IDLE;
            default:    state_nxt = MDU_IDLE;
        endcase
    end

    always_comb begin
        hilo_bus = '0;
        stallreq = 1'b0;
        busy     = (state != MDU_IDLE);
        unique case (state)
            MDU_IDLE: begin
                if (inst_mthi) begin
                    hilo_bus.hi_we    = 1'b1;
                    hilo_bus.hi_wdata = src_a;
                end else if (inst_mtlo) begin
                    hilo_bus.lo_we    = 1'b1;
                    hilo_bus.lo_wdata = src_a;
                end
                stallreq = is_div | is_mul;
            end
            MDU_DIV_ON: stallreq = 1'b1;
            MDU_MUL_ON: stallreq = ITER_MUL;
            MDU_DONE: begin
                hilo_bus = '{hi_we: 1'b1, lo_we: 1'b1, hi_wdata: hi_res, lo_wdata: lo_res};
            end
            default: ;
        endcase
    end

    assign ex_hilo = hilo_bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_res <= '0;
            lo_res <= '0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            mul_op <= 1'b0;
        end else if (state == MDU_IDLE) begin
            if (is_div) begin
                // Quotient sign follows the operand signs; remainder follows the dividend.
                neg_lo <= inst_div && (src_a[31] ^ src_b[31]);
                neg_hi <= inst_div && src_a[31];
                mul_op <= 1'b0;
                if (div_by_zero) begin
                    hi_res <= src_a;
                    lo_res <= DIV_ZERO_LO;
                end
            end else if (is_mul) begin
                mul_op <= 1'b1;
`ifdef MDU_MULT_ITER_EN
                neg_lo <= inst_mult && (src_a[31] ^ src_b[31]);
`else
                {hi_res, lo_res} <= inst_mult ? s_prod : u_prod;
`endif
            end
        end else if (core_done) begin
            if (mul_op) begin
                {hi_res, lo_res} <= prod_fix;
            end else begin
                hi_res <= neg_hi ? (~core_rem + 32'd1) : core_rem;
                lo_res <= neg_lo ? (~core_quo + 32'd1) : core_quo;
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed corner cases plus randomized ops against an arithmetic model.
// The EX stage is modelled as holding the instruction while stallreq or ex_stall is high.
module tb_hilo_mdu;

    typedef enum int {OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO} op_e;

`ifdef MDU_MULT_ITER_EN
    localparam bit ITER_MUL = 1'b1;
`else
    localparam bit ITER_MUL = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        inst_mult, inst_multu, inst_div, inst_divu, inst_mthi, inst_mtlo;
    logic [31:0] src_a, src_b;
    logic        ex_stall;
    logic [65:0] ex_hilo;
    logic        stallreq;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    hilo_mdu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_mult  (inst_mult),
        .inst_multu (inst_multu),
        .inst_div   (inst_div),
        .inst_divu  (inst_divu),
        .inst_mthi  (inst_mthi),
        .inst_mtlo  (inst_mtlo),
        .src_a      (src_a),
        .src_b      (src_b),
        .ex_stall   (ex_stall),
        .ex_hilo    (ex_hilo),
        .stallreq   (stallreq),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic drive(input op_e k, input logic [31:0] a, input logic [31:0] b);
        inst_mult  = (k == OP_MULT);
        inst_multu = (k == OP_MULTU);
        inst_div   = (k == OP_DIV);
        inst_divu  = (k == OP_DIVU);
        inst_mthi  = (k == OP_MTHI);
        inst_mtlo  = (k == OP_MTLO);
        src_a      = a;
        src_b      = b;
    endtask

    // Architectural result and timing, derived from plain arithmetic.
    function automatic void model(input op_e k, input logic [31:0] a, input logic [31:0] b,
                                  output logic [65:0] bus, output int n_stall, output int wr_cyc);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] q, r;
        sa      = longint'($signed(a));
        sb      = longint'($signed(b));
        bus     = '0;
        n_stall = 0;
        wr_cyc  = 1;
        case (k)
            OP_MTHI: bus = {2'b10, a, 32'h0};
            OP_MTLO: bus = {2'b01, 32'h0, a};
            OP_MULT, OP_MULTU: begin
                if (k == OP_MULT) p = sa * sb;
                else              p = {32'h0, a} * {32'h0, b};
                bus     = {2'b11, p};
                n_stall = ITER_MUL ? 33 : 1;
                wr_cyc  = ITER_MUL ? 34 : 3;
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'h0) begin
                    r       = a;
                    q       = 32'hFFFF_FFFF;
                    n_stall = 1;
                    wr_cyc  = 2;
                end else begin
                    if (k == OP_DIV) begin
                        q = 32'(sa / sb);
                        r = 32'(sa % sb);
                    end else begin
                        q = a / b;
                        r = a % b;
                    end
                    n_stall = 33;
                    wr_cyc  = 34;
                end
                bus = {2'b11, r, q};
            end
            default: ;
        endcase
    endfunction

    // Issue one instruction, optionally holding EX for `hold` cycles once the write appears.
    task automatic run_op(input op_e k, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        logic [65:0] exp_bus;
        logic [65:0] first_bus;
        int          exp_stall, exp_wr;
        int          n_stall, first_wr, n_wr, n_bad, n_dirty;
        logic        in_ex, busy_c2, busy_last;
        model(k, a, b, exp_bus, exp_stall, exp_wr);
        n_stall = 0; first_wr = 0; n_wr = 0; n_bad = 0; n_dirty = 0;
        first_bus = '0; in_ex = 1'b1; busy_c2 = 1'b0; busy_last = 1'b1;
        for (int c = 1; c <= exp_wr + hold + 3; c++) begin
            drive(in_ex ? k : OP_NONE, a, b);
            ex_stall = (c >= exp_wr) && (c < exp_wr + hold);
            @(negedge clk);
            if (stallreq) n_stall++;
            if (ex_hilo[65] || ex_hilo[64]) begin
                n_wr++;
                if (first_wr == 0) begin
                    first_wr  = c;
                    first_bus = ex_hilo;
                end
                if (ex_hilo !== exp_bus) n_bad++;
            end else if (ex_hilo[63:0] != 64'h0) begin
                n_dirty++;
            end
            if (c == 2) busy_c2 = busy;
            busy_last = busy;
            if (!(stallreq || ex_stall)) in_ex = 1'b0;
            @(posedge clk);
            #1;
        end
        drive(OP_NONE, 32'h0, 32'h0);
        ex_stall = 1'b0;
        check($sformatf("%s result", tag), first_bus, exp_bus);
        check($sformatf("%s stall_cycles", tag), 66'(n_stall), 66'(exp_stall));
        check($sformatf("%s write_cycle", tag), 66'(first_wr), 66'(exp_wr));
        check($sformatf("%s write_count", tag), 66'(n_wr), 66'(hold + 1));
        check($sformatf("%s repeat_writes", tag), 66'(n_bad), 66'(0));
        check($sformatf("%s idle_bus_clean", tag), 66'(n_dirty), 66'(0));
        check($sformatf("%s busy_c2", tag), 66'(busy_c2), 66'((k == OP_MTHI || k == OP_MTLO) ? 0 : 1));
        check($sformatf("%s busy_end", tag), 66'(busy_last), 66'(0));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic reset_abort_test();
        int n_wr, n_busy, n_stall;
        drive(OP_DIV, 32'd1000, 32'd3);
        // Cycle 1 is the IDLE start; cycle 12 is DIV_ON iteration 10.
        for (int c = 1; c < 12; c++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("abort busy_before", 66'(busy), 66'(1));
        #1;
        rst_n = 1'b0;
        drive(OP_NONE, 32'h0, 32'h0);
        #1;
        check("abort ex_hilo", ex_hilo, 66'h0);
        check("abort stallreq", 66'(stallreq), 66'(0));
        check("abort busy", 66'(busy), 66'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_wr = 0; n_busy = 0; n_stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ex_hilo[65] || ex_hilo[64]) n_wr++;
            if (busy) n_busy++;
            if (stallreq) n_stall++;
        end
        check("abort no_write", 66'(n_wr), 66'(0));
        check("abort idle_after", 66'(n_busy + n_stall), 66'(0));
    endtask

    initial begin
        op_e         k;
        logic [31:0] a, b;
        int          hold;
        rst_n    = 1'b0;
        ex_stall = 1'b0;
        drive(OP_NONE, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ex_hilo", ex_hilo, 66'h0);
        check("reset stallreq", 66'(stallreq), 66'(0));
        check("reset busy", 66'(busy), 66'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, "div_m7_2");
        run_op(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 0, "divu_max_16");
        run_op(OP_DIV,   32'h0000_0005, 32'h0000_0000, 0, "div_5_0");
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 0, "mult_m3_5");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        run_op(OP_MTHI,  32'h0000_1234, 32'h0,         0, "mthi");
        run_op(OP_MTLO,  32'h0000_ABCD, 32'h0,         0, "mtlo");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
        run_op(OP_DIVU,  32'd100,       32'd7,         3, "divu_100_7_hold");
        reset_abort_test();

        for (int i = 0; i < 40; i++) begin
            k    = op_e'($urandom_range(1, 6));
            a    = pick_operand();
            b    = pick_operand();
            hold = (k == OP_MTHI || k == OP_MTLO) ? 0 : int'($urandom_range(0, 2));
            run_op(k, a, b, hold, $sformatf("rand%0d_%s", i, k.name()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
